// File: rtl/pipeline_debug_unit.sv
// pipeline_debug_unit: host-facing debug controller for the MIPS pipeline.
// Decodes single-byte UART commands to run, single-step or pause the
// pipeline through a registered clock-enable, then captures the probe bus
// into a snapshot and streams it out byte-by-byte, word 0 first, each word
// little-endian.
//
// Transmit handshake: a byte moves only in a cycle where tx_valid and
// tx_ready are both 1. tx_valid is a function of the state alone (never of
// tx_ready); once raised it stays high with tx_data stable until the
// transfer, and with tx_ready held high one byte moves per cycle.

module pipeline_debug_unit #(
    parameter int NUM_WORDS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic [32*NUM_WORDS-1:0] probe_bus,
    input  logic                   halt_detected,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   pipe_enable,
    output logic                   busy
);

    localparam int NUM_BYTES = NUM_WORDS * 4;
    localparam int CNT_W     = $clog2(NUM_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

    localparam logic [7:0] CMD_CONT  = 8'h63;  // 'c'
    localparam logic [7:0] CMD_STEP  = 8'h73;  // 's'
    localparam logic [7:0] CMD_DUMP  = 8'h64;  // 'd'
    localparam logic [7:0] CMD_PAUSE = 8'h70;  // 'p'

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_LATCH = 3'd3,
        ST_SEND  = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    pipe_enable_next;
    logic                    xfer;
    logic [32*NUM_WORDS-1:0] snapshot;
    logic [32*NUM_WORDS-1:0] snap_shifted;
    logic [CNT_W-1:0]        byte_cnt;

    // A byte leaves only on a completed valid/ready handshake.
    assign xfer = tx_valid && tx_ready;

    // Select the byte addressed by the counter; idle output reads as zero.
    assign snap_shifted = snapshot >> {byte_cnt, 3'b000};
    assign tx_valid     = (state == ST_SEND);
    assign tx_data      = tx_valid ? snap_shifted[7:0] : 8'h00;
    assign busy         = (state != ST_IDLE);

    // Next-state decode; commands are only honoured in IDLE (and 'p' in RUN),
    // everything else is silently dropped.
    always_comb begin
        state_next       = state;
        pipe_enable_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_CONT: state_next = ST_RUN;
                        CMD_STEP: state_next = ST_STEP;
                        CMD_DUMP: state_next = ST_LATCH;
                        default:  state_next = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                // A halt beats a simultaneous pause so the halt is always dumped.
                if (halt_detected) begin
                    state_next = ST_LATCH;
                end else if (rx_valid && (rx_data == CMD_PAUSE)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_STEP:  state_next = ST_LATCH;
            ST_LATCH: state_next = ST_SEND;
            ST_SEND: begin
                if (xfer && (byte_cnt == LAST_BYTE)) begin
                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
        // The enable is registered, so it follows the state being entered.
        pipe_enable_next = (state_next == ST_RUN) || (state_next == ST_STEP);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered pipeline clock-enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_enable <= 1'b0;
        end else begin
            pipe_enable <= pipe_enable_next;
        end
    end

    // Snapshot capture in LATCH and byte counter advance on each transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            snapshot <= '0;
            byte_cnt <= '0;
        end else if (state == ST_LATCH) begin
            snapshot <= probe_bus;
            byte_cnt <= '0;
        end else if (xfer) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_debug_unit.sv
// tb_pipeline_debug_unit: randomized bench for pipeline_debug_unit with a
// transaction-level reference model. A stand-in pipeline advances a step
// counter on each enabled edge; the model predicts how many enabled edges a
// command produces and which probe value the dump must carry.

module tb_pipeline_debug_unit;

    localparam int NW = 2;
    localparam int NB = NW * 4;

    localparam int K_DUMP   = 0;
    localparam int K_STEP   = 1;
    localparam int K_HALT   = 2;  // 'c', halt raised in cycle n (n=0: already present)
    localparam int K_HALT_P = 3;  // 'c', halt and 'p' together in cycle n
    localparam int K_PAUSE  = 4;  // 'c', 'p' in cycle n
    localparam int K_JUNK   = 5;  // non-command byte in IDLE

    // ---------------- clock / reset / signals ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [32*NW-1:0] probe_bus;
    logic [32*NW-1:0] probe_base = '0;
    logic          halt_detected = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          pipe_enable;
    logic          busy;

    logic [31:0]   step_cnt = 0;
    logic [31:0]   model_steps = 0;
    logic [7:0]    exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            n_xfer = 0;

    always #5 clk = ~clk;

    pipeline_debug_unit #(.NUM_WORDS(NW)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .probe_bus     (probe_bus),
        .halt_detected (halt_detected),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .pipe_enable   (pipe_enable),
        .busy          (busy)
    );

    // Probe contents as a function of how far the pipeline has advanced.
    function automatic logic [63:0] probe_at(logic [63:0] base, logic [31:0] steps);
        return base ^ {steps * 32'h9E3779B9, steps * 32'h85EBCA6B};
    endfunction

    // Stand-in pipeline: advances only on edges where the enable is high.
    assign probe_bus = probe_at(probe_base, step_cnt);
    always @(posedge clk) begin
        if (pipe_enable === 1'b1) step_cnt <= step_cnt + 1;
    end

    // ---------------- checking ----------------
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected byte stream of one dump: word 0 first, little-endian words.
    task automatic push_dump(logic [63:0] v);
        for (int i = 0; i < NB; i++) exp_q.push_back(v[8*i +: 8]);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic       prev_rst = 1'b1;
    logic [7:0] prev_d = 8'h00;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (!prev_rst && prev_v && !prev_r) begin
            check("tx_hold_valid", 32'(tx_valid), 32'd1);
            check("tx_hold_data", 32'(tx_data), 32'(prev_d));
        end
        if (!reset && tx_valid === 1'b1 && tx_ready) begin
            if (exp_q.size() > 0) begin
                exp_b = exp_q.pop_front();
                check("tx_byte", 32'(tx_data), 32'(exp_b));
                n_xfer++;
            end else begin
                check("tx_unexpected", 32'(tx_valid), 32'd0);
            end
        end
        if (tx_valid === 1'b1) check("pe_in_send", 32'(pipe_enable), 32'd0);
        prev_v   = tx_valid;
        prev_r   = tx_ready;
        prev_rst = reset;
        prev_d   = tx_data;
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic ready_for(int mode, int idx);
        case (mode)
            0:       return 1'b1;
            1:       return (idx % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    function automatic logic [7:0] junk_byte();
        logic [7:0] b;
        b = 8'h41;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b != 8'h63 && b != 8'h73 && b != 8'h64) break;
            b = 8'h41;
        end
        return b;
    endfunction

    // One host command and everything the model expects to follow from it.
    task automatic do_op(int kind, int n, int mode, bit inject);
        int  e;
        bit  dump;
        int  cyc;
        e    = 0;
        dump = 1'b0;
        case (kind)
            K_DUMP:   begin e = 0; dump = 1'b1; end
            K_STEP:   begin e = 1; dump = 1'b1; end
            K_HALT:   begin e = (n == 0) ? 1 : n; dump = 1'b1; end
            K_HALT_P: begin e = n; dump = 1'b1; end
            K_PAUSE:  begin e = n; dump = 1'b0; end
            default:  begin e = 0; dump = 1'b0; end
        endcase
        if (dump) push_dump(probe_at(probe_base, model_steps + e));

        // Command phase up to and including the LATCH/return-to-idle cycle.
        for (cyc = 0; cyc <= e + 1; cyc++) begin
            next_cycle();
            tx_ready = ready_for(mode, cyc);
            if (cyc == 0) begin
                rx_valid = 1'b1;
                case (kind)
                    K_DUMP:  rx_data = 8'h64;
                    K_STEP:  rx_data = 8'h73;
                    K_JUNK:  rx_data = junk_byte();
                    default: rx_data = 8'h63;
                endcase
                if (kind == K_HALT && n == 0) halt_detected = 1'b1;
            end
            if ((kind == K_HALT || kind == K_HALT_P) && n > 0 && cyc == n) halt_detected = 1'b1;
            if ((kind == K_HALT_P || kind == K_PAUSE) && n > 0 && cyc == n) begin
                rx_valid = 1'b1;
                rx_data  = 8'h70;
            end
            sample();
            check("tx_valid_pre", 32'(tx_valid), 32'd0);
            if (cyc == 0) begin
                check("busy_c0", 32'(busy), 32'd0);
            end else begin
                check("pipe_enable", 32'(pipe_enable), 32'(cyc <= e));
                check("busy", 32'(busy), 32'(dump || (cyc <= e)));
            end
        end

        // Send phase: first byte is due exactly at cycle e+2.
        if (dump) begin
            for (int t = 0; t < 300; t++) begin
                next_cycle();
                tx_ready = ready_for(mode, cyc - (e + 2));
                if (inject && cyc == e + 3) begin rx_valid = 1'b1; rx_data = 8'h73; end
                if (inject && cyc == e + 4) begin rx_valid = 1'b1; rx_data = 8'h41; end
                sample();
                if (cyc == e + 2) check("tx_first", 32'(tx_valid), 32'd1);
                if (busy !== 1'b1) break;
                cyc++;
            end
            check("busy_end", 32'(busy), 32'd0);
            check("dump_left", 32'(exp_q.size()), 32'd0);
            if (mode == 0) check("dump_len", 32'(cyc), 32'(e + 2 + NB));
            exp_q.delete();
        end

        // Idle tail: nothing buffered may fire afterwards.
        for (int t = 0; t < 2; t++) begin
            next_cycle();
            halt_detected = 1'b0;
            tx_ready = 1'b1;
            sample();
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_pe", 32'(pipe_enable), 32'd0);
            check("idle_tx", 32'(tx_valid), 32'd0);
        end
        model_steps += 32'(e);
        check("steps", step_cnt, model_steps);
    endtask

    // Start a dump, let three bytes go, then reset in the middle of SEND.
    task automatic reset_mid_send();
        int x0;
        probe_base = {$urandom, $urandom};
        push_dump(probe_at(probe_base, model_steps));
        x0 = n_xfer;
        next_cycle();
        rx_valid = 1'b1;
        rx_data  = 8'h64;
        tx_ready = 1'b1;
        sample();
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            sample();
        end
        next_cycle();
        reset = 1'b1;
        sample();
        next_cycle();
        reset = 1'b0;
        sample();
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_xfers", 32'(n_xfer - x0), 32'd3);
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // Reset held two cycles with command strobes that must be ignored.
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            rx_valid = 1'b1;
            rx_data  = 8'h63;
        end
        next_cycle();
        reset = 1'b0;
        sample();
        check("reset_tx_valid", 32'(tx_valid), 32'd0);
        check("reset_pe", 32'(pipe_enable), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_tx_data", 32'(tx_data), 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            sample();
            check("post_reset_busy", 32'(busy), 32'd0);
            check("post_reset_pe", 32'(pipe_enable), 32'd0);
        end

        // Dump order and backpressure on the reference snapshot.
        probe_base = {32'hCAFEBABE, 32'h12345678};
        do_op(K_DUMP, 0, 0, 1'b0);
        do_op(K_DUMP, 0, 1, 1'b0);

        probe_base = {$urandom, $urandom};
        do_op(K_STEP, 0, 0, 1'b0);
        do_op(K_HALT, 5, 0, 1'b0);
        do_op(K_PAUSE, 3, 0, 1'b0);
        do_op(K_HALT_P, 2, 0, 1'b0);
        do_op(K_HALT, 0, 0, 1'b0);
        do_op(K_DUMP, 0, 1, 1'b1);
        do_op(K_JUNK, 0, 0, 1'b0);

        reset_mid_send();
        do_op(K_DUMP, 0, 0, 1'b0);

        // Randomized command mix.
        for (int i = 0; i < 40; i++) begin
            int kind;
            int n;
            probe_base = {$urandom, $urandom};
            kind = $urandom_range(0, 5);
            case (kind)
                K_HALT:  n = $urandom_range(0, 8);
                K_HALT_P, K_PAUSE: n = $urandom_range(1, 8);
                default: n = 0;
            endcase
            do_op(kind, n, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Bound on total runtime in case the design never releases busy.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipeline_debug_unit.md
# pipeline_debug_unit

Debug controller that sits between a byte-oriented UART pair and the MIPS `Pipeline`, letting a host drive the pipeline instead of a simulation bench. It decodes single-byte commands to run, single-step, or pause the pipeline through a clock-enable. It captures a snapshot of the pipeline probe signals, such as `PC_sumado_IF`, `instruction_ID` and `ALU_result_EX`, and streams the snapshot out byte-by-byte over a valid/ready transmit handshake.

## Interface
- `NUM_WORDS`, default 8: number of 32-bit probe words in one snapshot.
- `clk`: input, 1 bit. Single clock, rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `rx_data`: input, 8 bits. Command byte, valid only while `rx_valid` is high.
- `rx_valid`: input, 1 bit. One-cycle strobe from the UART receiver.
- `probe_bus`: input, 32*NUM_WORDS bits. Pipeline probe words; word k occupies bits [32k+31:32k].
- `halt_detected`: input, 1 bit. High while a halt instruction is present in the pipeline.
- `tx_data`: output, 8 bits. Byte offered to the UART transmitter.
- `tx_valid`: output, 1 bit. `tx_data` is valid.
- `tx_ready`: input, 1 bit. Transmitter accepts the byte.
- `pipe_enable`: output, 1 bit. Registered clock-enable for every pipeline register, PC and register file.
- `busy`: output, 1 bit. High whenever the state is not IDLE.

## Operation
- **States:** IDLE, RUN, STEP, LATCH, SEND.
- **Commands** are decoded only in IDLE, or in RUN for `p`. All other bytes, and all bytes in other states, are dropped. There is no buffering.
  - `c` (0x63) in IDLE: go to RUN.
  - `s` (0x73) in IDLE: go to STEP.
  - `d` (0x64) in IDLE: go to LATCH.
  - `p` (0x70) in RUN: go to IDLE with no dump.
- **RUN:** `pipe_enable` is 1. If `halt_detected` is 1 in a cycle, the next state is LATCH. If `p` and `halt_detected` arrive in the same cycle, the halt wins and the unit goes to LATCH.
- **STEP:** `pipe_enable` is 1 for exactly one cycle, then the state is LATCH.
- **LATCH:** `pipe_enable` is 0. `probe_bus` is registered into the snapshot at the end of the cycle, the byte counter is cleared, and the next state is SEND.
- **SEND:** the snapshot is sent as NUM_WORDS*4 bytes.
  - Word 0 goes first. Each word is sent little-endian, so the first byte of word k is bits [32k+7:32k].
  - The byte counter advances only on a transfer, i.e. a cycle where `tx_valid` and `tx_ready` are both 1.
  - After the transfer of byte NUM_WORDS*4-1, the state returns to IDLE.
- **Handshake:**
  - `tx_valid`, once asserted, stays high and `tx_data` stays stable until the transfer.
  - `tx_valid` does not depend combinationally on `tx_ready`.
  - Back-to-back transfers are allowed when `tx_ready` is held high: one byte per cycle, with no bubble.
- **Snapshot stability:** the snapshot is frozen during SEND. `probe_bus` changes have no effect because `pipe_enable` is 0 there.
- **Counter width:** clog2(NUM_WORDS*4+1) bits. The counter never wraps; the end condition is an equality compare.
- **Reset:** effective at the next edge.
  - State goes to IDLE.
  - `tx_valid`, `pipe_enable` and `busy` go to 0; `tx_data` goes to 0x00.
  - Snapshot and counter go to 0.
  - Reset during SEND abandons the dump. The byte in flight is not completed.
- **Halt already present:** `c` issued while `halt_detected` is already 1 gives exactly one enabled cycle, then a dump.

## Timing
- Cycle numbers below are relative to the edge at which the command byte is sampled with `rx_valid` = 1 (cycle 0).
- **`d` latency:** cycle 1 is LATCH. In cycle 2, `tx_valid` = 1 with byte 0.
- **`s` latency:**
  - Cycle 1 is STEP, with `pipe_enable` = 1, so the pipeline advances at the end of cycle 1.
  - Cycle 2 is LATCH and captures the post-step probes.
  - Cycle 3 is the first `tx_valid`.
- **`c` latency:**
  - `pipe_enable` = 1 from cycle 1.
  - Let H be the first cycle in RUN with `halt_detected` = 1. The edge ending cycle H is the last enabled edge.
  - `pipe_enable` = 0 from cycle H+1, which is LATCH.
  - The first byte appears in cycle H+2.
- **Full dump duration:** with `tx_ready` tied high, a dump takes NUM_WORDS*4 cycles of SEND. `busy` falls in the cycle after the last transfer.
- **`p` latency:** `pipe_enable` = 0 in the cycle after `p` is sampled.

## Test plan
- **Reset values:** hold `reset` for 2 cycles and send `rx_valid` pulses during it. Afterwards `tx_valid` = 0, `pipe_enable` = 0, `busy` = 0, and no state change occurs.
- **Dump order, `tx_ready` = 1:** NUM_WORDS=2, `probe_bus` = {0xCAFEBABE, 0x12345678}, send `d`. Expect bytes 78 56 34 12 BE BA FE CA on consecutive cycles starting at cycle 2, then `busy` = 0.
- **Backpressure:** same setup with `tx_ready` toggling 1,0,0,1,... Expect `tx_data` stable while stalled, exactly 8 transfers in the same order, and no duplicated or skipped byte.
- **Step:** send `s` while the bench changes `probe_bus` only when `pipe_enable` = 1. Expect exactly one `pipe_enable` cycle, and the dump shows the post-step value.
- **Run/halt and pause:**
  - Send `c`, then raise `halt_detected` 5 cycles later. Expect `pipe_enable` high for exactly 5 cycles, then an automatic dump.
  - Separately, send `c` then `p`. Expect `pipe_enable` to fall next cycle with no `tx_valid`.
- **Dropped and illegal commands:**
  - Send `s` and 0x41 during SEND. Both are ignored.
  - Assert `reset` mid-SEND. `tx_valid` = 0 the next cycle and the state is IDLE.
